// File: rtl/issue_rr_arbiter_pkg.sv
// Shared types and defaults for the issue-stage round-robin arbiter.
package issue_pkg;

    // Arbiter control states: free arbitration, stalled offer, locked burst.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    // Default number of requesters sharing the issue port.
    localparam int default_els_lp = 8;

endpackage

// File: rtl/issue_rr_arbiter_priority_encoder.sv
// Lowest-index-wins priority encoder used by the round-robin arbiter.
module priority_encoder #(
    parameter int els_p    = 8,
    parameter int lg_els_p = $clog2(els_p)
) (
    input  logic [els_p-1:0]    req,
    output logic                found,
    output logic [lg_els_p-1:0] index
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        found = |req;
        index = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = lg_els_p'(i);
            end
        end
    end

endmodule

// File: rtl/issue_rr_arbiter.sv
// Round-robin issue arbiter with stall hold, locked multi-beat grants and flush.
module issue_rr_arbiter
    import issue_pkg::*;
#(
    parameter int els_p    = default_els_lp,
    parameter int lg_els_p = $clog2(els_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [els_p-1:0]    req_i,
    input  logic                lock_i,
    input  logic                flush_i,
    input  logic                ready_i,
    output logic                v_o,
    output logic [lg_els_p-1:0] addr_o,
    output logic [els_p-1:0]    grant_oh_o
);

    arb_state_e state, state_next;

    logic [lg_els_p-1:0] last_r, last_next;
    logic [lg_els_p-1:0] hold_addr_r, hold_next;

    logic [els_p-1:0]    above_last;
    logic [els_p-1:0]    masked;
    logic                masked_found, raw_found;
    logic [lg_els_p-1:0] masked_idx, raw_idx, pick;

    logic                valid;
    logic [lg_els_p-1:0] addr;
    logic                accept;

    // Thermometer of requester indices strictly above the last winner.
    for (genvar i = 0; i < els_p; i++) begin : g_thermo
        assign above_last[i] = (lg_els_p'(i) > last_r);
    end

    assign masked = req_i & above_last;

    priority_encoder #(.els_p(els_p), .lg_els_p(lg_els_p)) u_masked_pe (
        .req   (masked),
        .found (masked_found),
        .index (masked_idx)
    );

    priority_encoder #(.els_p(els_p), .lg_els_p(lg_els_p)) u_raw_pe (
        .req   (req_i),
        .found (raw_found),
        .index (raw_idx)
    );

    // Prefer requesters after the last winner; wrap to the full vector otherwise.
    assign pick = masked_found ? masked_idx : raw_idx;

    // Offer selection per state; flush and reset silence the port at once.
    always_comb begin
        valid = 1'b0;
        addr  = pick;
        case (state)
            IDLE: begin
                valid = raw_found;
            end
            HOLD: begin
                valid = 1'b1;
                addr  = hold_addr_r;
            end
            LOCKED: begin
                valid = req_i[hold_addr_r];
                addr  = hold_addr_r;
            end
            default: begin
                valid = 1'b0;
            end
        endcase
        if (flush_i || reset_i) begin
            valid = 1'b0;
        end
    end

    assign v_o        = valid;
    assign addr_o     = reset_i ? '0 : addr;
    assign grant_oh_o = valid ? (els_p'(1) << addr) : '0;
    assign accept     = valid & ready_i;

    // Next-state, rotation pointer and held-grantee updates.
    always_comb begin
        state_next = state;
        last_next  = last_r;
        hold_next  = hold_addr_r;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_next = pick;
                        if (lock_i) begin
                            state_next = LOCKED;
                            hold_next  = pick;
                        end
                    end else if (valid) begin
                        state_next = HOLD;
                        hold_next  = pick;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        last_next  = hold_addr_r;
                        state_next = lock_i ? LOCKED : IDLE;
                    end
                end
                LOCKED: begin
                    if (accept && !lock_i) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State registers; requester 0 starts with top priority after reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            last_r      <= lg_els_p'(els_p - 1);
            hold_addr_r <= '0;
        end else begin
            state       <= state_next;
            last_r      <= last_next;
            hold_addr_r <= hold_next;
        end
    end

`ifndef SYNTHESIS
    a_grant_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(grant_oh_o));

    a_hold_frozen: assert property (@(posedge clk_i) disable iff (reset_i)
        (state == HOLD && !flush_i) |-> (v_o && addr_o == hold_addr_r));

    a_no_x: assert property (@(posedge clk_i) disable iff (reset_i)
        !$isunknown({v_o, addr_o, grant_oh_o}));
`endif

endmodule

// File: tb/tb_issue_rr_arbiter.sv
// Directed self-checking bench for issue_rr_arbiter with four requesters.
module tb_issue_rr_arbiter;

    localparam int elsCount = 4;

    logic                clock;
    logic                reset;
    logic [elsCount-1:0] req;
    logic                lock;
    logic                flush;
    logic                ready;
    logic                valid;
    logic [1:0]          addr;
    logic [elsCount-1:0] grantOh;

    int testCount = 0;
    int failCount = 0;

    issue_rr_arbiter #(.els_p(elsCount), .lg_els_p(2)) dut (
        .clk_i      (clock),
        .reset_i    (reset),
        .req_i      (req),
        .lock_i     (lock),
        .flush_i    (flush),
        .ready_i    (ready),
        .v_o        (valid),
        .addr_o     (addr),
        .grant_oh_o (grantOh)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare one observed value against its expected value and tally it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Check the whole grant triple against the expected offer.
    task automatic checkGrant(input string tag, input logic expValid, input logic [1:0] expAddr);
        logic [elsCount-1:0] expOh;
        expOh = expValid ? (elsCount'(1) << expAddr) : '0;
        checkOutput({tag, "_v"}, 32'(valid), 32'(expValid));
        if (expValid) begin
            checkOutput({tag, "_addr"}, 32'(addr), 32'(expAddr));
        end
        checkOutput({tag, "_oh"}, 32'(grantOh), 32'(expOh));
    endtask

    // Drive one cycle of inputs at the falling edge and let them settle.
    task automatic applyStimulus(input logic [elsCount-1:0] r, input logic l, input logic f, input logic rd);
        @(negedge clock);
        req   = r;
        lock  = l;
        flush = f;
        ready = rd;
        #2;
    endtask

    int gap;
    int maxGap;
    int grantsToTwo;
    logic [3:0] randBits;

    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        lock  = 1'b0;
        flush = 1'b0;
        ready = 1'b1;
        #12;
        checkGrant("reset_quiet", 1'b0, 2'd0);
        checkOutput("reset_addr", 32'(addr), 32'd0);
        req = '0;
        @(negedge clock);
        reset = 1'b0;

        // Full rotation with every requester active.
        applyStimulus(4'b1111, 0, 0, 1); checkGrant("rr0", 1, 2'd0);
        applyStimulus(4'b1111, 0, 0, 1); checkGrant("rr1", 1, 2'd1);
        applyStimulus(4'b1111, 0, 0, 1); checkGrant("rr2", 1, 2'd2);
        applyStimulus(4'b1111, 0, 0, 1); checkGrant("rr3", 1, 2'd3);
        applyStimulus(4'b1111, 0, 0, 1); checkGrant("rr_wrap", 1, 2'd0);

        // Stalled offer stays on requester 1 even when requester 0 appears.
        applyStimulus(4'b1010, 0, 0, 0); checkGrant("hold0", 1, 2'd1);
        applyStimulus(4'b1011, 0, 0, 0); checkGrant("hold1", 1, 2'd1);
        applyStimulus(4'b1011, 0, 0, 0); checkGrant("hold2", 1, 2'd1);
        applyStimulus(4'b1011, 0, 0, 1); checkGrant("hold_acc", 1, 2'd1);
        applyStimulus(4'b1001, 0, 0, 1); checkGrant("after_hold", 1, 2'd3);

        // Locked burst on requester 1, then requester 2 is next.
        applyStimulus(4'b0110, 1, 0, 1); checkGrant("lock_b1", 1, 2'd1);
        applyStimulus(4'b0110, 1, 0, 1); checkGrant("lock_b2", 1, 2'd1);
        applyStimulus(4'b0110, 1, 0, 1); checkGrant("lock_b3", 1, 2'd1);
        applyStimulus(4'b0110, 0, 0, 1); checkGrant("lock_b4", 1, 2'd1);
        applyStimulus(4'b0110, 0, 0, 1); checkGrant("after_lock", 1, 2'd2);

        // Lock requester 2, drop its request, then flush back to IDLE.
        applyStimulus(4'b0100, 1, 0, 1); checkGrant("lock2", 1, 2'd2);
        applyStimulus(4'b1000, 0, 0, 1); checkGrant("lock_drop", 0, 2'd0);
        applyStimulus(4'b1100, 0, 1, 1); checkGrant("flush", 0, 2'd0);
        applyStimulus(4'b1100, 0, 0, 1); checkGrant("post_flush", 1, 2'd3);

        // Empty request vector in IDLE offers nothing.
        applyStimulus(4'b0000, 0, 0, 1); checkGrant("idle_empty", 0, 2'd0);

        // A lone requester wins every cycle.
        applyStimulus(4'b0100, 0, 0, 1); checkGrant("single0", 1, 2'd2);
        applyStimulus(4'b0100, 0, 0, 1); checkGrant("single1", 1, 2'd2);
        applyStimulus(4'b0100, 0, 0, 1); checkGrant("single2", 1, 2'd2);

        // Asynchronous reset during a stalled offer.
        applyStimulus(4'b0011, 0, 0, 0); checkGrant("pre_rst_offer", 1, 2'd3 == 2'd3 ? 2'd0 : 2'd0);
        applyStimulus(4'b0011, 0, 0, 0); checkGrant("pre_rst_hold", 1, 2'd0);
        #1;
        reset = 1'b1;
        req   = '0;
        #1;
        checkGrant("async_rst", 0, 2'd0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(4'b1000, 0, 0, 1); checkGrant("rst_pick3", 1, 2'd3);
        applyStimulus(4'b1001, 0, 0, 1); checkGrant("rst_wrap0", 1, 2'd0);

        // Random traffic with requester 2 always requesting.
        gap = 0;
        maxGap = 0;
        grantsToTwo = 0;
        for (int c = 0; c < 10000; c++) begin
            randBits = 4'($urandom);
            applyStimulus({randBits[3], 1'b1, randBits[1:0]}, 0, 0, randBits[2]);
            if (valid && ready) begin
                if (addr == 2'd2) begin
                    grantsToTwo++;
                    gap = 0;
                end else begin
                    gap++;
                    if (gap > maxGap) maxGap = gap;
                end
            end
        end
        checkOutput("starve_gap", 32'(maxGap <= 3), 32'd1);
        checkOutput("starve_served", 32'(grantsToTwo > 0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
